instr_sequencer: RTL and testbench

- Multi-cycle control sequencer for the Divvy core.
- Steps each instruction through FETCH, EXEC, optional MEM and WB, using the decode outputs of the instruction-control decoder (Branch, MemStatus, WriteRegEn, WriteACCEn, HALT).
- Gates every architectural write with one-cycle strobes.
- Owns the Start/Done program handshake, the data-memory request/ready handshake, and a retired-instruction counter.

---
 rtl/divvy_pkg.sv | 23 ++
 rtl/seq_wait_timer.sv | 36 +++
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 tb/tb_instr_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/divvy_pkg.sv
// Shared types and constants for the Divvy core control path.
package divvy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } SeqState;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  // 2'b11 is not a legal access and falls through as "no memory access".
  function automatic logic mem_access(input logic [1:0] status);
    return (status == MEM_LOAD) || (status == MEM_STORE);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Clear/enable wait counter for the MEM state; expired_o flags the last allowed wait cycle.
module seq_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  // A timeout of 1 still needs a 1-bit counter.
  localparam int unsigned Width = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == Width'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB control sequencer for the Divvy core.
module instr_sequencer
  import divvy_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Branch,
  input  logic             BranchCond,
  input  logic [1:0]       MemStatus,
  input  logic             WriteRegEn,
  input  logic             WriteACCEn,
  input  logic             MemReady,
  output logic             PcClear,
  output logic             PcEn,
  output logic             PcTarget,
  output logic             IrLoad,
  output logic             MemReq,
  output logic             MemWe,
  output logic             RegWrStb,
  output logic             AccWrStb,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] InstrCount
);

  SeqState          state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wait_clr, wait_en, wait_expired;

  // The wait counter only runs while MEM is stalled, and restarts on every MEM entry.
  assign wait_clr = (state_q != MEM);
  assign wait_en  = (state_q == MEM) && !MemReady && !wait_expired;

  seq_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .clear_i  (wait_clr),
    .en_i     (wait_en),
    .expired_o(wait_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = FETCH;
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        if (Halt) begin
          state_d = DONE;
        end else if (mem_access(MemStatus)) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (MemReady) begin
          state_d = WB;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end
      WB: state_d = FETCH;
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && Start) begin
      count_d = '0;
    end else if (state_q == WB && count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    PcClear  = 1'b0;
    PcEn     = 1'b0;
    PcTarget = 1'b0;
    IrLoad   = 1'b0;
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    RegWrStb = 1'b0;
    AccWrStb = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    Error    = 1'b0;
    case (state_q)
      IDLE: PcClear = Start;
      FETCH: begin
        IrLoad = 1'b1;
        Busy   = 1'b1;
      end
      EXEC: Busy = 1'b1;
      MEM: begin
        MemReq = 1'b1;
        MemWe  = (MemStatus == MEM_STORE);
        Busy   = 1'b1;
      end
      WB: begin
        Busy     = 1'b1;
        RegWrStb = WriteRegEn;
        AccWrStb = WriteACCEn;
        PcEn     = 1'b1;
        PcTarget = Branch & BranchCond;
      end
      DONE:    Done  = 1'b1;
      ERR:     Error = 1'b1;
      default: ;
    endcase
  end

  assign InstrCount = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: per-cycle directed stimulus pushes expected outputs, a monitor compares.
module tb_instr_sequencer;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 2;

  localparam logic [10:0] O_NONE  = 11'b000_0000_0000;
  localparam logic [10:0] O_PCCLR = 11'b100_0000_0000;
  localparam logic [10:0] O_PCEN  = 11'b010_0000_0000;
  localparam logic [10:0] O_PCTGT = 11'b001_0000_0000;
  localparam logic [10:0] O_IRL   = 11'b000_1000_0000;
  localparam logic [10:0] O_MREQ  = 11'b000_0100_0000;
  localparam logic [10:0] O_MWE   = 11'b000_0010_0000;
  localparam logic [10:0] O_REGW  = 11'b000_0001_0000;
  localparam logic [10:0] O_ACCW  = 11'b000_0000_1000;
  localparam logic [10:0] O_BUSY  = 11'b000_0000_0100;
  localparam logic [10:0] O_DONE  = 11'b000_0000_0010;
  localparam logic [10:0] O_ERR   = 11'b000_0000_0001;

  logic            Clk = 1'b0;
  logic            Reset_n, Start, Halt, Branch, BranchCond, WriteRegEn, WriteACCEn, MemReady;
  logic [1:0]      MemStatus;
  logic            PcClear, PcEn, PcTarget, IrLoad, MemReq, MemWe, RegWrStb, AccWrStb;
  logic            Busy, Done, Error;
  logic [CntW-1:0] InstrCount;

  typedef struct {
    logic [10:0]     outs;
    logic [CntW-1:0] cnt;
    string           tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  instr_sequencer #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Halt      (Halt),
    .Branch    (Branch),
    .BranchCond(BranchCond),
    .MemStatus (MemStatus),
    .WriteRegEn(WriteRegEn),
    .WriteACCEn(WriteACCEn),
    .MemReady  (MemReady),
    .PcClear   (PcClear),
    .PcEn      (PcEn),
    .PcTarget  (PcTarget),
    .IrLoad    (IrLoad),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .RegWrStb  (RegWrStb),
    .AccWrStb  (AccWrStb),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error),
    .InstrCount(InstrCount)
  );

  logic [10:0] act;
  assign act = {PcClear, PcEn, PcTarget, IrLoad, MemReq, MemWe, RegWrStb, AccWrStb,
                Busy, Done, Error};

  // Monitor: mid-cycle, compare against the oldest expectation.
  always @(negedge Clk) begin
    if (sb_q.size() != 0) begin
      exp_t x;
      x = sb_q.pop_front();
      checks++;
      if (act !== x.outs || InstrCount !== x.cnt) begin
        errors++;
        $display("FAIL %s: outputs %b count %0d, expected outputs %b count %0d",
                 x.tag, act, InstrCount, x.outs, x.cnt);
      end
    end
  end

  // One clock cycle: apply inputs, record the expected response, advance.
  task automatic cyc(input logic rst_n, input logic start, input logic halt, input logic br,
                     input logic bc, input logic [1:0] ms, input logic wr, input logic wa,
                     input logic mr, input logic [10:0] e, input logic [CntW-1:0] c,
                     input string tag);
    exp_t x;
    Reset_n    = rst_n;
    Start      = start;
    Halt       = halt;
    Branch     = br;
    BranchCond = bc;
    MemStatus  = ms;
    WriteRegEn = wr;
    WriteACCEn = wa;
    MemReady   = mr;
    x.outs = e;
    x.cnt  = c;
    x.tag  = tag;
    sb_q.push_back(x);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Halt = 1'b0; Branch = 1'b0; BranchCond = 1'b0;
    MemStatus = 2'b00; WriteRegEn = 1'b0; WriteACCEn = 1'b0; MemReady = 1'b0;
    @(posedge Clk);
    #1;

    // ALU op writing ACC, then HALT; Start held through DONE.
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE,                  0, "reset_idle");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 1, 0, O_PCCLR,                 0, "a_start");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 1, 0, O_IRL | O_BUSY,          0, "a_fetch");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 1, 0, O_BUSY,                  0, "a_exec");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 1, 0, O_PCEN | O_ACCW | O_BUSY, 0, "a_wb");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_IRL | O_BUSY,          1, "h_fetch");
    cyc(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, O_BUSY,                  1, "h_exec");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_DONE,                  1, "a_done");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_DONE,                  1, "done_hold");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_DONE,                  1, "done_release");

    // Load, MemReady low for 3 MEM cycles then high.
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_PCCLR,                 1, "b_start");
    cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 0, O_IRL | O_BUSY,          0, "b_fetch");
    cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 0, O_BUSY,                  0, "b_exec");
    cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 0, O_MREQ | O_BUSY,         0, "b_mem0");
    cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 0, O_MREQ | O_BUSY,         0, "b_mem1");
    cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 0, O_MREQ | O_BUSY,         0, "b_mem2");
    cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 1, O_MREQ | O_BUSY,         0, "b_mem3");
    cyc(1, 1, 0, 0, 0, 2'b01, 1, 0, 0, O_PCEN | O_REGW | O_BUSY, 0, "b_wb");

    // Store with immediate ready, no write enables.
    cyc(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, O_IRL | O_BUSY,          1, "c_fetch");
    cyc(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, O_BUSY,                  1, "c_exec");
    cyc(1, 1, 0, 0, 0, 2'b10, 0, 0, 1, O_MREQ | O_MWE | O_BUSY, 1, "c_mem");
    cyc(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, O_PCEN | O_BUSY,         1, "c_wb");

    // Branches with Start dropped while busy; InstrCount saturates at 3.
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_IRL | O_BUSY,          2, "d_fetch");
    cyc(1, 0, 0, 1, 1, 2'b00, 0, 0, 0, O_BUSY,                  2, "d_exec");
    cyc(1, 0, 0, 1, 1, 2'b00, 0, 0, 0, O_PCEN | O_PCTGT | O_BUSY, 2, "d_wb_taken");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_IRL | O_BUSY,          3, "e_fetch");
    cyc(1, 0, 0, 1, 0, 2'b11, 0, 0, 0, O_BUSY,                  3, "e_exec_ms11");
    cyc(1, 0, 0, 1, 0, 2'b11, 0, 0, 0, O_PCEN | O_BUSY,         3, "e_wb_not_taken");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_IRL | O_BUSY,          3, "cnt_saturated");
    cyc(1, 0, 1, 0, 0, 2'b01, 0, 0, 0, O_BUSY,                  3, "halt_over_mem");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_DONE,                  3, "e_done");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE,                  3, "e_idle");

    // Memory timeout: 4 stalled MEM cycles then sticky ERR until reset.
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_PCCLR,                 3, "t_start");
    cyc(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, O_IRL | O_BUSY,          0, "t_fetch");
    cyc(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, O_BUSY,                  0, "t_exec");
    cyc(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, O_MREQ | O_BUSY,         0, "t_mem0");
    cyc(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, O_MREQ | O_BUSY,         0, "t_mem1");
    cyc(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, O_MREQ | O_BUSY,         0, "t_mem2");
    cyc(1, 1, 0, 0, 0, 2'b01, 0, 0, 0, O_MREQ | O_BUSY,         0, "t_mem3");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_ERR,                   0, "t_err");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_ERR,                   0, "t_err_start1");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_ERR,                   0, "t_err_start0");
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_ERR,                   0, "t_err_rst");
    cyc(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, O_NONE,                  0, "t_idle_after_rst");

    // Reset asserted mid-MEM after one retired instruction.
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_PCCLR,                 0, "r_start");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_IRL | O_BUSY,          0, "r_fetch");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_BUSY,                  0, "r_exec");
    cyc(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, O_PCEN | O_BUSY,         0, "r_wb");
    cyc(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, O_IRL | O_BUSY,          1, "r_fetch2");
    cyc(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, O_BUSY,                  1, "r_exec2");
    cyc(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, O_MREQ | O_MWE | O_BUSY, 1, "r_mem");
    cyc(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, O_MREQ | O_MWE | O_BUSY, 1, "r_mem_rst");
    cyc(1, 0, 0, 0, 0, 2'b10, 0, 0, 0, O_NONE,                  0, "rst_mem_idle");

    @(negedge Clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
